muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
- Responder for ALU-operand requests. Accepts forwarded SrcA/SrcB with a Start pulse, runs a multi-cycle MULT/MULTU/DIV/DIVU, and writes the HI/LO architectural registers.
- Busy is used by the hazard unit to stall IF/ID/EX. It also services MTHI/MTLO writes and drives HI/LO for MFHI/MFLO forwarding.

---
 rtl/muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit for the EX stage of the 5-stage MIPS
//   pipeline. Runs MULT/MULTU/DIV/DIVU over ITER iterations and owns the
//   HI/LO architectural registers (also written by MTHI/MTLO).
//
// Ports:
//   clk     in   pipeline clock, rising edge
//   rstn    in   asynchronous active-low reset
//   Start   in   one-cycle request from EX, sampled only in IDLE
//   Op      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA    in   rs operand (forwarded)
//   SrcB    in   rt operand (forwarded)
//   Flush   in   aborts the operation in flight, HI/LO untouched
//   MthiEn  in   HI <= SrcA (IDLE only, Start has priority)
//   MtloEn  in   LO <= SrcA (IDLE only, Start has priority)
//   Busy    out  high whenever the FSM is not IDLE (stall request)
//   Done    out  one-cycle pulse when an operation updates HI/LO
//   Hi/Lo   out  HI/LO registers
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   Defined: MULT/MULTU use a single-cycle multiplier (IDLE -> FIN), HI/LO
//   and Done appear in the first Busy cycle. DIV/DIVU are unchanged.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic              Flush,
  input  logic              MthiEn,
  input  logic              MtloEn,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_prod;    // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]  r_div;     // |multiplicand| or |divisor|
  logic [DATA_W-1:0]  r_srca;    // raw dividend, needed for divide-by-zero result
  logic               r_is_div;
  logic               r_neg_q;   // negate product / quotient
  logic               r_neg_r;   // negate remainder
  logic               r_dz;      // divide by zero
  logic               r_fast;    // operation already completed in IDLE
  logic               r_done;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;

  logic               w_signed;
  logic [DATA_W-1:0]  w_abs_a;
  logic [DATA_W-1:0]  w_abs_b;
  logic [DATA_W:0]    w_mul_sum;
  logic [PW-1:0]      w_mul_next;
  logic [DATA_W:0]    w_div_top;
  logic [DATA_W:0]    w_div_diff;
  logic               w_qbit;
  logic [DATA_W-1:0]  w_rem_next;
  logic [PW-1:0]      w_div_next;
  logic [PW-1:0]      w_mul_res;
  logic [DATA_W-1:0]  w_quo;
  logic [DATA_W-1:0]  w_rem;
  logic               w_fast_go;
  logic [PW-1:0]      w_fast_prod;

  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

  // Op[0]=0 selects the signed variants; iterate on magnitudes.
  assign w_signed = ~Op[0];
  assign w_abs_a  = (w_signed && SrcA[DATA_W-1]) ? (~SrcA + DATA_W'(1)) : SrcA;
  assign w_abs_b  = (w_signed && SrcB[DATA_W-1]) ? (~SrcB + DATA_W'(1)) : SrcB;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole product right (carry enters at the top).
  assign w_mul_sum  = {1'b0, r_prod[PW-1:DATA_W]} +
                      (r_prod[0] ? {1'b0, r_div} : {(DATA_W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_prod[DATA_W-1:1]};

  // Restoring divide step: the shifted remainder can need DATA_W+1 bits
  // before the trial subtraction, so it is taken straight from the top bits.
  assign w_div_top  = r_prod[PW-1:DATA_W-1];
  assign w_div_diff = w_div_top - {1'b0, r_div};
  assign w_qbit     = ~w_div_diff[DATA_W];
  assign w_rem_next = w_qbit ? w_div_diff[DATA_W-1:0] : w_div_top[DATA_W-1:0];
  assign w_div_next = {w_rem_next, r_prod[DATA_W-2:0], w_qbit};

  // Sign correction applied in FIN.
  assign w_mul_res = r_neg_q ? (~r_prod + PW'(1)) : r_prod;
  assign w_quo     = r_neg_q ? (~r_prod[DATA_W-1:0] + DATA_W'(1)) : r_prod[DATA_W-1:0];
  assign w_rem     = r_neg_r ? (~r_prod[PW-1:DATA_W] + DATA_W'(1)) : r_prod[PW-1:DATA_W];

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] w_ext_a;
  logic [PW-1:0] w_ext_b;
  assign w_ext_a     = {{DATA_W{w_signed & SrcA[DATA_W-1]}}, SrcA};
  assign w_ext_b     = {{DATA_W{w_signed & SrcB[DATA_W-1]}}, SrcB};
  // Low PW bits of the extended product are the exact signed/unsigned result.
  assign w_fast_prod = w_ext_a * w_ext_b;
  assign w_fast_go   = ~Op[1];
`else
  assign w_fast_prod = {PW{1'b0}};
  assign w_fast_go   = 1'b0;
`endif

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_prod   <= {PW{1'b0}};
      r_div    <= {DATA_W{1'b0}};
      r_srca   <= {DATA_W{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_fast   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {DATA_W{1'b0}};
      r_lo     <= {DATA_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            // Start with Flush is dropped; MT writes are ignored either way.
            if (!Flush) begin
              if (w_fast_go) begin
                {r_hi, r_lo} <= w_fast_prod;
                r_done       <= 1'b1;
                r_fast       <= 1'b1;
                r_state      <= S_FIN;
              end else begin
                r_prod   <= {{DATA_W{1'b0}}, w_abs_a};
                r_div    <= w_abs_b;
                r_srca   <= SrcA;
                r_is_div <= Op[1];
                r_neg_q  <= w_signed & (SrcA[DATA_W-1] ^ SrcB[DATA_W-1]);
                r_neg_r  <= w_signed & Op[1] & SrcA[DATA_W-1];
                r_dz     <= Op[1] & (SrcB == {DATA_W{1'b0}});
                r_fast   <= 1'b0;
                r_cnt    <= {CNT_W{1'b0}};
                r_state  <= S_CALC;
              end
            end
          end else begin
            if (MthiEn) begin
              r_hi <= SrcA;
            end
            if (MtloEn) begin
              r_lo <= SrcA;
            end
          end
        end
        S_CALC: begin
          if (Flush) begin
            r_state <= S_IDLE;
          end else begin
            r_prod <= r_is_div ? w_div_next : w_mul_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          if (!Flush && !r_fast) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_mul_res;
            end else if (r_dz) begin
              r_hi <= r_srca;
              r_lo <= {DATA_W{1'b1}};
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed + small random bench for muldiv_unit. Expected HI/LO pairs are
//   queued when an operation starts and popped when Done pulses.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        MthiEn;
  logic        MtloEn;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  muldiv_unit #(.DATA_W(32), .ITER(32)) dut (
    .clk(clk), .rstn(rstn), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .MthiEn(MthiEn), .MtloEn(MtloEn),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int         MUL_LAT  = 1;
  localparam int         MUL_BUSY = 1;
  localparam logic [1:0] RST_OP   = 2'b10;
`else
  localparam int         MUL_LAT  = 34;
  localparam int         MUL_BUSY = 33;
  localparam logic [1:0] RST_OP   = 2'b00;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: MIPS semantics incl. divide-by-zero and overflow cases.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint p;
    int     sa;
    int     sb;
    sa = $signed(a);
    sb = $signed(b);
    r  = 64'd0;
    case (op)
      2'b00: begin p = longint'(sa) * longint'(sb); r = p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; r = p; end
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
        else begin r.lo = sa / sb; r.hi = sa % sb; end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin r.lo = a / b; r.hi = a % b; end
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every Done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_hi", {32'd0, Hi}, {32'd0, mon_e.hi});
        chk("result_lo", {32'd0, Lo}, {32'd0, mon_e.lo});
      end
    end
  end

  // Start one op (optionally with MthiEn), then wait for Done with a bound.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int exp_lat, input int exp_busy, input logic mt);
    int          lat;
    int          busy;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    pre_hi = Hi;
    pre_lo = Lo;
    sb_q.push_back(e);
    Op = op; SrcA = a; SrcB = b; Start = 1'b1; MthiEn = mt;
    @(posedge clk); #1;
    Start = 1'b0; MthiEn = 1'b0; SrcA = ~a; SrcB = 32'd0;
    lat  = 0;
    busy = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (Busy === 1'b1) busy++;
      if (c == 1 && exp_lat > 1) begin
        chk("hold_hi", {32'd0, Hi}, {32'd0, pre_hi});
        chk("hold_lo", {32'd0, Lo}, {32'd0, pre_lo});
      end
      if (Done === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(busy), 64'(exp_busy));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          done_cnt;

    rstn = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = 32'd0; SrcB = 32'd0;
    Flush = 1'b0; MthiEn = 1'b0; MtloEn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_hi", {32'd0, Hi}, 64'd0);
    chk("rst_lo", {32'd0, Lo}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // MTHI and MTLO in the same cycle
    SrcA = 32'hA5A50001; MthiEn = 1'b1; MtloEn = 1'b1;
    @(posedge clk); #1;
    MthiEn = 1'b0; MtloEn = 1'b0;
    @(negedge clk);
    chk("mt_both_hi", {32'd0, Hi}, {32'd0, 32'hA5A50001});
    chk("mt_both_lo", {32'd0, Lo}, {32'd0, 32'hA5A50001});
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFF, 32'hFFFFFFEB}, MUL_LAT, MUL_BUSY, 1'b0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, MUL_LAT, MUL_BUSY, 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 33, 1'b0);
    run_op(2'b11, 32'd100,      32'd0,        {32'd100,      32'hFFFFFFFF}, 34, 33, 1'b0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 34, 33, 1'b0);
    @(negedge clk);
    chk("ovf_no_x", {Hi, Lo}, {32'h00000000, 32'h80000000});
    chk("ovf_ctl_no_x", {62'd0, Busy, Done}, 64'd0);
    @(posedge clk); #1;
    run_op(2'b10, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 34, 33, 1'b0);
    run_op(2'b10, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, 33, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'(i);
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(31, 0);
      if (rb == 32'd0) rb = 32'd3;
      run_op(rop, ra, rb, model(rop, ra, rb), rop[1] ? 34 : MUL_LAT, rop[1] ? 33 : MUL_BUSY, 1'b0);
    end

    // Preload HI/LO, then flush a DIVU at cycle 10
    SrcA = 32'd5; MthiEn = 1'b1;
    @(posedge clk); #1;
    MthiEn = 1'b0; SrcA = 32'd6; MtloEn = 1'b1;
    @(posedge clk); #1;
    MtloEn = 1'b0;
    @(negedge clk);
    chk("pre_hi", {32'd0, Hi}, 64'd5);
    chk("pre_lo", {32'd0, Lo}, 64'd6);
    @(posedge clk); #1;
    Op = 2'b11; SrcA = 32'd50; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_c10", {63'd0, Busy}, 64'd1);
    @(posedge clk); #1;
    Flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_c11", {63'd0, Busy}, 64'd0);
    chk("flush_hi", {32'd0, Hi}, 64'd5);
    chk("flush_lo", {32'd0, Lo}, 64'd6);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) done_cnt++;
    end
    chk("flush_no_done", 64'(done_cnt), 64'd0);
    @(posedge clk); #1;

    // Start wins over MTHI in the same cycle
    run_op(2'b11, 32'd50, 32'd3, {32'd2, 32'd16}, 34, 33, 1'b1);

    // Asynchronous reset in the middle of an operation
    Op = RST_OP; SrcA = 32'h00001234; SrcB = 32'h00000077; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_done", {63'd0, Done}, 64'd0);
    chk("midrst_hi", {32'd0, Hi}, 64'd0);
    chk("midrst_lo", {32'd0, Lo}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst_busy", {63'd0, Busy}, 64'd0);
    repeat (3) @(posedge clk);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
